// File: rtl/mips_wb_pkg.sv
// Shared constants and bundle types for the register-file
// writeback path.
package mips_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Strict FIFO of deferred long-latency writeback results.
// Pointers wrap modulo QDEPTH; full/empty come from count.
module wb_fifo
  import mips_wb_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic      clk,
  input  logic      SYS_reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic [CW-1:0] count,
  output logic      full,
  output logic      empty
);

  wb_entry_t mem [QDEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port master: pipeline writeback first,
// then queued/bypassed long-latency results, plus busy scoreboard.
module reg_wb_arbiter
  import mips_wb_pkg::*;
#(
  parameter int DATA_W = mips_wb_pkg::DATA_W,
  parameter int ADDR_W = mips_wb_pkg::ADDR_W,
  parameter int QDEPTH = 4,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              SYS_reset,
  input  logic              pipe_wb_valid,
  input  logic [ADDR_W-1:0] pipe_wb_addr,
  input  logic [DATA_W-1:0] pipe_wb_data,
  input  logic              lat_issue_valid,
  input  logic [ADDR_W-1:0] lat_issue_addr,
  input  logic              lat_done_valid,
  input  logic [ADDR_W-1:0] lat_done_addr,
  input  logic [DATA_W-1:0] lat_done_data,
  output logic              lat_done_ready,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              hazard_stall,
  output logic              REG_write_enable,
  output logic [ADDR_W-1:0] REG_address_wr,
  output logic [DATA_W-1:0] REG_write_data,
  output logic [CW-1:0]     q_count,
  output logic              sb_err
);

  logic [NREG-1:0] busy;
  wb_entry_t       q_head;
  wb_entry_t       q_din;
  logic            q_full;
  logic            q_empty;

  logic pipe_go;
  logic lat_acc;
  logic lat_nz;
  logic do_pop;
  logic do_bypass;
  logic do_push;
  logic do_issue;

  assign lat_done_ready = !SYS_reset && !q_full;
  assign lat_acc   = lat_done_valid && lat_done_ready;
  assign lat_nz    = (lat_done_addr != ZERO_REG);
  assign pipe_go   = pipe_wb_valid && (pipe_wb_addr != ZERO_REG);
  assign do_pop    = !pipe_go && !q_empty;
  // Bypass only when nothing older is queued, keeping FIFO order.
  assign do_bypass = !pipe_go && q_empty && lat_acc && lat_nz;
  assign do_push   = lat_acc && lat_nz && !do_bypass;
  assign do_issue  = lat_issue_valid
                  && (lat_issue_addr != ZERO_REG);

  assign q_din = '{addr: lat_done_addr, data: lat_done_data};

  wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .SYS_reset (SYS_reset),
    .push      (do_push),
    .pop       (do_pop),
    .din       (q_din),
    .dout      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign hazard_stall =
      ((chk_addr1 != ZERO_REG) && busy[chk_addr1])
   || ((chk_addr2 != ZERO_REG) && busy[chk_addr2]);

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      REG_write_enable <= 1'b0;
      REG_address_wr   <= '0;
      REG_write_data   <= '0;
    end else begin
      REG_write_enable <= 1'b0;
      unique case (1'b1)
        pipe_go: begin
          REG_write_enable <= 1'b1;
          REG_address_wr   <= pipe_wb_addr;
          REG_write_data   <= pipe_wb_data;
        end
        do_pop: begin
          REG_write_enable <= 1'b1;
          REG_address_wr   <= q_head.addr;
          REG_write_data   <= q_head.data;
        end
        do_bypass: begin
          REG_write_enable <= 1'b1;
          REG_address_wr   <= lat_done_addr;
          REG_write_data   <= lat_done_data;
        end
        default: ;
      endcase
    end
  end

  // Set is applied after clear so a same-cycle reissue wins.
  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      if (do_pop)         busy[q_head.addr]   <= 1'b0;
      else if (do_bypass) busy[lat_done_addr] <= 1'b0;
      if (do_issue) begin
        busy[lat_issue_addr] <= 1'b1;
        if (busy[lat_issue_addr]) sb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter with a
// negedge-sampling register-file model.
module tb_reg_wb_arbiter;

  logic        clk;
  logic        SYS_reset;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_addr;
  logic [31:0] pipe_wb_data;
  logic        lat_issue_valid;
  logic [4:0]  lat_issue_addr;
  logic        lat_done_valid;
  logic [4:0]  lat_done_addr;
  logic [31:0] lat_done_data;
  logic        lat_done_ready;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        hazard_stall;
  logic        REG_write_enable;
  logic [4:0]  REG_address_wr;
  logic [31:0] REG_write_data;
  logic [2:0]  q_count;
  logic        sb_err;

  int n_chk;
  int n_fail;

  logic [31:0] rf [32];

  reg_wb_arbiter #(.QDEPTH(4)) dut (
    .clk              (clk),
    .SYS_reset        (SYS_reset),
    .pipe_wb_valid    (pipe_wb_valid),
    .pipe_wb_addr     (pipe_wb_addr),
    .pipe_wb_data     (pipe_wb_data),
    .lat_issue_valid  (lat_issue_valid),
    .lat_issue_addr   (lat_issue_addr),
    .lat_done_valid   (lat_done_valid),
    .lat_done_addr    (lat_done_addr),
    .lat_done_data    (lat_done_data),
    .lat_done_ready   (lat_done_ready),
    .chk_addr1        (chk_addr1),
    .chk_addr2        (chk_addr2),
    .hazard_stall     (hazard_stall),
    .REG_write_enable (REG_write_enable),
    .REG_address_wr   (REG_address_wr),
    .REG_write_data   (REG_write_data),
    .q_count          (q_count),
    .sb_err           (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (REG_write_enable && REG_address_wr != 5'd0)
      rf[REG_address_wr] <= REG_write_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    SYS_reset = 1'b1;
    #1;
    n_chk++;
    if (REG_write_enable !== 1'b0 || REG_address_wr !== 5'd0
        || REG_write_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_out: got we=%b a=%0d d=%h want 0/0/0",
               REG_write_enable, REG_address_wr, REG_write_data);
    end
    tick();
    n_chk++;
    if (q_count !== 3'd0 || sb_err !== 1'b0
        || lat_done_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got q=%0d err=%b rdy=%b want 0/0/0",
               q_count, sb_err, lat_done_ready);
    end
    SYS_reset = 1'b0;
    #1;
    n_chk++;
    if (lat_done_ready !== 1'b1 || hazard_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b hz=%b want 1/0",
               lat_done_ready, hazard_stall);
    end
    tick();
    n_chk++;
    if (REG_write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_nowrite: got we=%b want 0",
               REG_write_enable);
    end
  endtask

  task automatic test_pipe_write();
    pipe_wb_valid = 1'b1;
    pipe_wb_addr  = 5'd8;
    pipe_wb_data  = 32'hDEADBEEF;
    tick();
    pipe_wb_valid = 1'b0;
    n_chk++;
    if (REG_write_enable !== 1'b1 || REG_address_wr !== 5'd8
        || REG_write_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL pipe_wr: got we=%b a=%0d d=%h want 1/8/deadbeef",
               REG_write_enable, REG_address_wr, REG_write_data);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (rf[8] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rf_r8: got %h want deadbeef", rf[8]);
    end
    tick();
    n_chk++;
    if (REG_write_enable !== 1'b0 || REG_address_wr !== 5'd8
        || REG_write_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL pipe_hold: got we=%b a=%0d d=%h want 0/8/deadbeef",
               REG_write_enable, REG_address_wr, REG_write_data);
    end
  endtask

  task automatic test_pipe_zero();
    pipe_wb_valid = 1'b1;
    pipe_wb_addr  = 5'd0;
    pipe_wb_data  = 32'hFFFFFFFF;
    tick();
    pipe_wb_valid = 1'b0;
    n_chk++;
    if (REG_write_enable !== 1'b0 || REG_address_wr !== 5'd8) begin
      n_fail++;
      $display("FAIL pipe_zero: got we=%b a=%0d want 0/8",
               REG_write_enable, REG_address_wr);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (rf[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL rf_r0: got %h want 0", rf[0]);
    end
  endtask

  task automatic test_lat_bypass();
    lat_issue_valid = 1'b1;
    lat_issue_addr  = 5'd5;
    tick();
    lat_issue_valid = 1'b0;
    chk_addr1 = 5'd5;
    #1;
    n_chk++;
    if (hazard_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL hz_set: got %b want 1", hazard_stall);
    end
    lat_done_valid = 1'b1;
    lat_done_addr  = 5'd5;
    lat_done_data  = 32'h1234;
    #1;
    n_chk++;
    if (lat_done_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL byp_rdy: got %b want 1", lat_done_ready);
    end
    tick();
    lat_done_valid = 1'b0;
    n_chk++;
    if (REG_write_enable !== 1'b1 || REG_address_wr !== 5'd5
        || REG_write_data !== 32'h1234 || q_count !== 3'd0) begin
      n_fail++;
      $display("FAIL bypass: got we=%b a=%0d d=%h q=%0d want 1/5/1234/0",
               REG_write_enable, REG_address_wr, REG_write_data,
               q_count);
    end
    n_chk++;
    if (hazard_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL hz_clear: got %b want 0", hazard_stall);
    end
    chk_addr1 = 5'd0;
  endtask

  task automatic test_queue();
    bit       exp_rdy [8] = '{1, 1, 1, 1, 0, 0, 0, 1};
    int       exp_q   [8] = '{1, 2, 3, 4, 4, 4, 3, 3};
    int       acc;
    int       ea;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      pipe_wb_valid  = (c < 6);
      pipe_wb_addr   = 5'(c + 1);
      pipe_wb_data   = 32'h1000 + 32'(c);
      lat_done_valid = (acc < 5);
      lat_done_addr  = 5'(10 + acc);
      lat_done_data  = 32'hA000_0000 + 32'(10 + acc);
      #1;
      n_chk++;
      if (lat_done_ready !== exp_rdy[c]) begin
        n_fail++;
        $display("FAIL q_rdy c%0d: got %b want %b",
                 c, lat_done_ready, exp_rdy[c]);
      end
      tick();
      if (lat_done_valid && exp_rdy[c]) acc++;
      ea = (c < 6) ? c + 1 : 10 + (c - 6);
      n_chk++;
      if (REG_write_enable !== 1'b1 || REG_address_wr !== 5'(ea)
          || REG_write_data !== ((c < 6) ? 32'h1000 + 32'(c)
                                 : 32'hA000_0000 + 32'(ea))
          || q_count !== 3'(exp_q[c])) begin
        n_fail++;
        $display("FAIL q_wr c%0d: got we=%b a=%0d d=%h q=%0d want a=%0d q=%0d",
                 c, REG_write_enable, REG_address_wr,
                 REG_write_data, q_count, ea, exp_q[c]);
      end
    end
    pipe_wb_valid  = 1'b0;
    lat_done_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (REG_write_enable !== 1'b1 || REG_address_wr !== 5'(12 + c)
          || REG_write_data !== 32'hA000_0000 + 32'(12 + c)
          || q_count !== 3'(2 - c)) begin
        n_fail++;
        $display("FAIL q_drain %0d: got we=%b a=%0d d=%h q=%0d want a=%0d q=%0d",
                 c, REG_write_enable, REG_address_wr,
                 REG_write_data, q_count, 12 + c, 2 - c);
      end
    end
    tick();
    n_chk++;
    if (REG_write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL q_idle: got we=%b want 0", REG_write_enable);
    end
  endtask

  task automatic test_sb_err();
    lat_issue_valid = 1'b1;
    lat_issue_addr  = 5'd7;
    tick();
    n_chk++;
    if (sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_first: got %b want 0", sb_err);
    end
    tick();
    lat_issue_valid = 1'b0;
    n_chk++;
    if (sb_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_dup: got %b want 1", sb_err);
    end
    chk_addr2 = 5'd7;
    #1;
    n_chk++;
    if (hazard_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL hz_src2: got %b want 1", hazard_stall);
    end
    pipe_wb_valid = 1'b1;
    pipe_wb_addr  = 5'd3;
    pipe_wb_data  = 32'h33;
    tick();
    pipe_wb_valid = 1'b0;
    n_chk++;
    if (sb_err !== 1'b1 || hazard_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_sticky: got err=%b hz=%b want 1/1",
               sb_err, hazard_stall);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int c = 0; c < 3; c++) begin
      pipe_wb_valid  = 1'b1;
      pipe_wb_addr   = 5'd1;
      pipe_wb_data   = 32'h77;
      lat_done_valid = 1'b1;
      lat_done_addr  = 5'(20 + c);
      lat_done_data  = 32'hB000_0000 + 32'(20 + c);
      tick();
    end
    pipe_wb_valid  = 1'b0;
    lat_done_valid = 1'b0;
    n_chk++;
    if (q_count !== 3'd3) begin
      n_fail++;
      $display("FAIL rst_fill: got q=%0d want 3", q_count);
    end
    tick();
    n_chk++;
    if (REG_write_enable !== 1'b1 || REG_address_wr !== 5'd20
        || q_count !== 3'd2) begin
      n_fail++;
      $display("FAIL rst_pop: got we=%b a=%0d q=%0d want 1/20/2",
               REG_write_enable, REG_address_wr, q_count);
    end
    #2;
    SYS_reset = 1'b1;
    #1;
    n_chk++;
    if (REG_write_enable !== 1'b0 || q_count !== 3'd0
        || sb_err !== 1'b0 || hazard_stall !== 1'b0
        || lat_done_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got we=%b q=%0d err=%b hz=%b rdy=%b want 0/0/0/0/0",
               REG_write_enable, q_count, sb_err, hazard_stall,
               lat_done_ready);
    end
    SYS_reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (REG_write_enable !== 1'b0 || q_count !== 3'd0) begin
        n_fail++;
        $display("FAIL rst_quiet %0d: got we=%b q=%0d want 0/0",
                 c, REG_write_enable, q_count);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    pipe_wb_valid   = 1'b0;
    pipe_wb_addr    = 5'd0;
    pipe_wb_data    = 32'd0;
    lat_issue_valid = 1'b0;
    lat_issue_addr  = 5'd0;
    lat_done_valid  = 1'b0;
    lat_done_addr   = 5'd0;
    lat_done_data   = 32'd0;
    chk_addr1       = 5'd0;
    chk_addr2       = 5'd0;
    test_reset();
    test_pipe_write();
    test_pipe_zero();
    test_lat_bypass();
    test_queue();
    test_sb_err();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Write-side master for the 32x32 register-file write port (REG_write_enable / REG_address_wr / REG_write_data).
- Merges two writer sources onto the single port:
  - the in-order pipeline writeback;
  - long-latency results (load miss, mult/div), which are queued.
- Keeps a per-register busy scoreboard so decode can stall on pending long-latency destinations.
- Drives registered outputs on posedge clk. The register file samples them on negedge clk and forwards same-cycle writes.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 5, register address width (32 registers).
- QDEPTH, 4, deferred-result queue depth (power of 2, >=2).

Ports:
- clk  in  1  clock, posedge-active.
- SYS_reset  in  1  reset, asynchronous, active-high.
- pipe_wb_valid  in  1  pipeline writeback request this cycle.
- pipe_wb_addr  in  ADDR_W  pipeline destination register.
- pipe_wb_data  in  DATA_W  pipeline writeback data.
- lat_issue_valid  in  1  long-latency op issued; reserve its destination.
- lat_issue_addr  in  ADDR_W  destination reserved at issue.
- lat_done_valid  in  1  long-latency result available.
- lat_done_addr  in  ADDR_W  result destination.
- lat_done_data  in  DATA_W  result data.
- lat_done_ready  out  1  result accepted when valid&&ready.
- chk_addr1  in  ADDR_W  decode source register 1.
- chk_addr2  in  ADDR_W  decode source register 2.
- hazard_stall  out  1  a source register is busy (combinational).
- REG_write_enable  out  1  register-file write enable (registered).
- REG_address_wr  out  ADDR_W  register-file write address (registered).
- REG_write_data  out  DATA_W  register-file write data (registered).
- q_count  out  clog2(QDEPTH)+1  queue occupancy.
- sb_err  out  1  sticky scoreboard protocol error.

Behaviour:
- Reset (async, immediate):
  - REG_write_enable=0, REG_address_wr=0, REG_write_data=0.
  - Queue empty, q_count=0, all busy bits clear, sb_err=0.
  - lat_done_ready forced 0 while SYS_reset=1.
  - No write issued after release from pre-reset state.
- Write-port arbitration, evaluated each posedge, in priority order:
  1. pipe_wb_valid && pipe_wb_addr!=0: load outputs from pipe, WE=1.
  2. Else queue non-empty: pop head, WE=1.
  3. Else lat_done accepted with addr!=0 (queue empty by construction): bypass directly to outputs, WE=1, no push.
  4. Else WE=0; address and data hold their last values.
- Latency: accepted request to WE asserted = 1 cycle.
- Address 0 is never written:
  - pipe writes to 0 are dropped;
  - accepted lat_done to addr 0 is consumed but neither queued nor written.
- lat_done_ready = !SYS_reset && (q_count<QDEPTH). No same-cycle pop credit when full.
- Accepted lat_done not bypassed is pushed to the queue tail. Queue is strict FIFO; a push and a pop in the same cycle are allowed.
- Pipe writes are never queued and never stall.
- Scoreboard, busy[31:0]:
  - lat_issue_valid && addr!=0 sets busy[addr] at posedge.
  - A long-latency write driven onto the port (pop or bypass) clears busy[addr] at the same posedge it loads the outputs.
  - Set and clear of the same address in one cycle: set wins.
  - Issue to an already-busy register sets sb_err=1. sb_err clears only on reset.
  - Pipe writes do not touch busy bits.
- hazard_stall = (chk_addr1!=0 && busy[chk_addr1]) || (chk_addr2!=0 && busy[chk_addr2]).
- Data stays correct during the write cycle: the register file forwards write data combinationally to readers.
- Queue wrap-around: pointers are modulo QDEPTH; full/empty are derived from q_count.

Decomposition:
- Package mips_wb_pkg holds:
  - DATA_W and ADDR_W constants;
  - ZERO_REG constant = 0;
  - wb_entry_t struct {addr, data}.
- Sub-module wb_fifo (parameter QDEPTH):
  - ports: push, pop, din, dout, count, full, empty;
  - async reset to empty.
- Arbitration and scoreboard stay in reg_wb_arbiter.

Test Plan:
- Pipe write, addr 8, data 0xDEADBEEF -> next cycle WE=1, addr 8, data 0xDEADBEEF; register-file readback of reg 8 = 0xDEADBEEF.
- Pipe write, addr 0, data 0xFFFFFFFF -> WE stays 0; reg 0 reads 0.
- lat_issue addr 5; chk_addr1=5 -> hazard_stall=1. lat_done addr 5, data 0x1234, pipe idle -> next cycle WE=1, addr 5, data 0x1234, busy[5] clear, hazard_stall=0.
- Pipe writes to addr 1..6 on 6 consecutive cycles, with lat_done to addr 10..14 offered each cycle:
  - 10..13 accepted, q_count reaches 4, ready=0, 14 stalls;
  - after pipe stops, writes 10, 11, 12, 13, 14 appear in order, one per cycle.
- lat_issue addr 7 twice without a completion between -> sb_err=1, still 1 after later traffic; reset clears it.
- Queue holding 3 entries, SYS_reset asserted mid-drain -> WE=0 and q_count=0 immediately, busy all 0; no writes after release until new requests.
